// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA pixel-stream source.
//   * 640x480@60 timing defaults and derived totals (800 x 525)
//   * rgb_t colour struct
//   * colour-bar table and bar-index helper for the optional test pattern
//     (VGA_TEST_PATTERN_EN)
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Index 0 is the leftmost bar.
    localparam rgb_t [0:7] BAR_RGB = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // x/80 for the visible range, built from compares instead of a divider.
    function automatic logic [2:0] bar_idx(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++)
            if (x >= 10'(i * 80)) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line -- DEPTH-stage register shift with async reset to RST_VAL.
//   VGA_CLK      pixel clock
//   VGA_RESET_N  async active-low reset, loads every stage with RST_VAL
//   d / q        WIDTH-bit input / output, q = d delayed DEPTH cycles
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             VGA_CLK,
    input  logic             VGA_RESET_N,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) begin
            stage <= {DEPTH{RST_VAL}};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480@60 VGA timing generator and pixel fetcher.
// Issues a coordinate request every visible cycle, realigns the returned
// colour with the sync/blank decode and drives registered oVGA_* outputs.
// Latency counter -> oVGA_* is PIX_LATENCY+1 cycles.
//   VGA_CLK, VGA_RESET_N       pixel clock, async active-low reset
//   pix_req, pix_x, pix_y      coordinate request to the frame source
//   iPIX_R/G/B                 colour returned PIX_LATENCY cycles later
//   test_en                    colour-bar select (VGA_TEST_PATTERN_EN only)
//   frame_start                one-cycle pulse after the (0,0) cycle
//   oVGA_R/G/B, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N  VGA outputs
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars).
// PIX_LATENCY legal range is 1..4.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_LATENCY = 1,
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP
) (
    input  logic       VGA_CLK,
    input  logic       VGA_RESET_N,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    input  logic [7:0] iPIX_R,
    input  logic [7:0] iPIX_G,
    input  logic [7:0] iPIX_B,
    input  logic       test_en,
    output logic       frame_start,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_SYNC_N,
    output logic       oVGA_BLANK_N
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt, v_cnt;
    logic       active, hs_n, vs_n, origin;
    logic       act_q, hs_q, vs_q;
    rgb_t       src_rgb;

    // ---------------- counters ----------------
    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // ---------------- stage-0 decode ----------------
    // vs_n follows v_cnt, so it naturally switches on the h_cnt=0 boundary.
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_n   = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    assign vs_n   = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    assign origin = (h_cnt == '0) && (v_cnt == '0);

    assign pix_req = active;
    assign pix_x   = h_cnt;
    assign pix_y   = v_cnt;

    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) frame_start <= 1'b0;
        else              frame_start <= origin;
    end

    // ---------------- alignment with the source latency ----------------
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIX_LATENCY),
        .RST_VAL (3'b011)          // blank, both syncs inactive
    ) u_align (
        .VGA_CLK     (VGA_CLK),
        .VGA_RESET_N (VGA_RESET_N),
        .d           ({active, hs_n, vs_n}),
        .q           ({act_q, hs_q, vs_q})
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] x_q;
    logic       test_sel;

    vga_delay_line #(
        .WIDTH   (10),
        .DEPTH   (PIX_LATENCY),
        .RST_VAL ('0)
    ) u_xdly (
        .VGA_CLK     (VGA_CLK),
        .VGA_RESET_N (VGA_RESET_N),
        .d           (h_cnt),
        .q           (x_q)
    );

    // Latched on the cycle that raises frame_start: the first pixel of the
    // frame reaches the output stage later, so a whole frame uses one mode.
    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) test_sel <= 1'b0;
        else if (origin)  test_sel <= test_en;
    end

    assign src_rgb = test_sel ? BAR_RGB[bar_idx(x_q)]
                              : '{r: iPIX_R, g: iPIX_G, b: iPIX_B};
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign src_rgb        = '{r: iPIX_R, g: iPIX_G, b: iPIX_B};
`endif

    // ---------------- output register ----------------
    // Colour is forced to 0 outside the visible area whatever the source drives.
    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            oVGA_R       <= act_q ? src_rgb.r : 8'h00;
            oVGA_G       <= act_q ? src_rgb.g : 8'h00;
            oVGA_B       <= act_q ? src_rgb.b : 8'h00;
            oVGA_HS      <= hs_q;
            oVGA_VS      <= vs_q;
            oVGA_BLANK_N <= act_q;
        end
    end

    assign oVGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- self-checking bench for vga_timing_gen.
// Full 800-cycle lines with a short 15-line frame (8 visible, VS on lines
// 10..11) so whole frames fit in the run. A 1-cycle source returns
// R=x, G=x^y, B=y for every coordinate, blanking included.
module tb_vga_timing_gen;

    localparam int HT = 800;
    localparam int VT = 15;
    localparam logic [27:0] BLANK_E = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};

    logic       VGA_CLK = 1'b0;
    logic       VGA_RESET_N = 1'b0;
    logic       pix_req, frame_start;
    logic [9:0] pix_x, pix_y;
    logic [7:0] iPIX_R = 8'h0, iPIX_G = 8'h0, iPIX_B = 8'h0;
    logic       test_en;
    logic [7:0] oVGA_R, oVGA_G, oVGA_B;
    logic       oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N;

    vga_timing_gen #(
        .PIX_LATENCY (1),
        .V_ACTIVE    (8),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (3)
    ) dut (
        .VGA_CLK      (VGA_CLK),
        .VGA_RESET_N  (VGA_RESET_N),
        .pix_req      (pix_req),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .iPIX_R       (iPIX_R),
        .iPIX_G       (iPIX_G),
        .iPIX_B       (iPIX_B),
        .test_en      (test_en),
        .frame_start  (frame_start),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B),
        .oVGA_HS      (oVGA_HS),
        .oVGA_VS      (oVGA_VS),
        .oVGA_SYNC_N  (oVGA_SYNC_N),
        .oVGA_BLANK_N (oVGA_BLANK_N)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    // Frame source with one cycle of latency.
    always @(posedge VGA_CLK) begin
        iPIX_R <= pix_x[7:0];
        iPIX_G <= pix_x[7:0] ^ pix_y[7:0];
        iPIX_B <= pix_y[7:0];
    end

    int          checks = 0, failures = 0;
    int          hx, vy, cyc_n;
    logic        prev_origin, prev_hs, prev_bl, fs_seen;
    int          hs_run, bl_run, fs_last, blank_runs, vs_low;
    logic [27:0] sb[$];

    function automatic logic [27:0] exp_out(input int x, input int y);
        logic act, hs, vs;
        logic [7:0] xl, yl;
        xl  = x[7:0];
        yl  = y[7:0];
        act = (x < 640) && (y < 8);
        hs  = !((x >= 656) && (x <= 751));
        vs  = !((y >= 10) && (y <= 11));
        return {act, hs, vs, 1'b0, act ? {xl, xl ^ yl, yl} : 24'h0};
    endfunction

    function automatic logic [27:0] obs_out();
        return {oVGA_BLANK_N, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_R, oVGA_G, oVGA_B};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (h=%0d v=%0d)", tag, obs, exp, hx, vy);
        end
    endtask

    task automatic sample();
        logic [27:0] e;
        logic        act;
        act = (hx < 640) && (vy < 8);
        chk("pix_req_xy", {11'd0, pix_req, pix_x, pix_y}, {11'd0, act, 10'(hx), 10'(vy)});
        chk("frame_start", {31'd0, frame_start}, {31'd0, prev_origin});
        e = sb.pop_front();
        chk("vga_out", {4'd0, obs_out()}, {4'd0, e});
        sb.push_back(exp_out(hx, vy));

        if (!oVGA_HS && prev_hs) chk("hs_start", hx, 658);
        if (!oVGA_HS) hs_run++;
        else if (!prev_hs) begin chk("hs_width", hs_run, 96); hs_run = 0; end
        if (oVGA_BLANK_N && !prev_bl) blank_runs++;
        if (oVGA_BLANK_N) bl_run++;
        else if (prev_bl) begin chk("blank_width", bl_run, 640); bl_run = 0; end
        if (!oVGA_VS) vs_low++;
        if (frame_start) begin
            if (fs_seen) begin
                chk("frame_period", cyc_n - fs_last, HT * VT);
                chk("blank_runs", blank_runs, 8);
                chk("vs_low", vs_low, 2 * HT);
            end
            fs_seen = 1'b1; fs_last = cyc_n; blank_runs = 0; vs_low = 0;
        end
        prev_hs     = oVGA_HS;
        prev_bl     = oVGA_BLANK_N;
        prev_origin = (hx == 0) && (vy == 0);
    endtask

    task automatic cyc();
        @(posedge VGA_CLK); #1;
        cyc_n++;
        hx++;
        if (hx == HT) begin
            hx = 0; vy++;
            if (vy == VT) vy = 0;
        end
        sample();
    endtask

    // Called just after reset release: the DUT sits at (0,0), outputs still reset.
    task automatic start_epoch();
        hx = 0; vy = 0;
        sb.delete();
        sb.push_back(BLANK_E);
        sb.push_back(BLANK_E);
        prev_origin = 1'b0; prev_hs = 1'b1; prev_bl = 1'b0; fs_seen = 1'b0;
        hs_run = 0; bl_run = 0; blank_runs = 0; vs_low = 0;
        #1;
        sample();
    endtask

    initial begin
        cyc_n = 0; hx = 0; vy = 0;
`ifdef VGA_TEST_PATTERN_EN
        test_en = 1'b0;
`else
        test_en = 1'b1;    // must have no effect
`endif
        VGA_RESET_N = 1'b0;
        repeat (5) begin
            @(posedge VGA_CLK); #1;
            chk("rst_out", {4'd0, obs_out()}, {4'd0, BLANK_E});
            chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        end
        @(negedge VGA_CLK);
        VGA_RESET_N = 1'b1;
        start_epoch();

        // Frame 0 complete, then on to (300,3) of frame 1.
        repeat (HT * VT + 3 * HT + 300) cyc();

        #1 VGA_RESET_N = 1'b0;
        #1;
        chk("arst_out", {4'd0, obs_out()}, {4'd0, BLANK_E});
        chk("arst_xy", {12'd0, pix_x, pix_y}, 32'd0);
        chk("arst_frame_start", {31'd0, frame_start}, 32'd0);
        repeat (2) @(posedge VGA_CLK);
        #1;
        chk("arst_hold_out", {4'd0, obs_out()}, {4'd0, BLANK_E});
        @(negedge VGA_CLK);
        VGA_RESET_N = 1'b1;
        start_epoch();
        repeat (3 * HT) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
